// File: rtl/pipe_ctrl.sv
// Pipeline control: stall, flush and halt sequencing for the five-stage core.
// Enables and flushes are combinational; halted and stall_cnt are registered.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_hazard,
  input  logic        branch_taken_EX,
  input  logic        halt_ID,
  input  logic        imem_stall,
  input  logic        dmem_stall,
  output logic        pc_en,
  output logic        IF_ID_en,
  output logic        ID_EX_en,
  output logic        EX_MEM_en,
  output logic        MEM_WB_en,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN,
    DMEM_WAIT,
    DRAIN,
    HALTED
  } state_t;

  state_t     state, ret_state, eff;
  state_t     nxt_state, nxt_ret;
  logic [1:0] drain_cnt, nxt_drain;
  logic       cnt_inc;

  always_comb begin
    pc_en       = 1'b0;
    IF_ID_en    = 1'b0;
    ID_EX_en    = 1'b0;
    EX_MEM_en   = 1'b0;
    MEM_WB_en   = 1'b0;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    cnt_inc     = 1'b0;
    nxt_ret     = ret_state;
    nxt_drain   = drain_cnt;
    // Release cycle of a data stall behaves as the state it interrupted
    eff = (state == DMEM_WAIT && !dmem_stall)
        ? ret_state : state;
    nxt_state = eff;
    if (rst) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else begin
      case (eff)
        DMEM_WAIT: cnt_inc = 1'b1;
        RUN: begin
          if (dmem_stall) begin
            cnt_inc   = 1'b1;
            nxt_state = DMEM_WAIT;
            nxt_ret   = RUN;
          end else if (branch_taken_EX) begin
            pc_en       = 1'b1;
            IF_ID_en    = 1'b1;
            ID_EX_en    = 1'b1;
            EX_MEM_en   = 1'b1;
            MEM_WB_en   = 1'b1;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
          end else if (stall_hazard) begin
            ID_EX_en    = 1'b1;
            ID_EX_flush = 1'b1;
            EX_MEM_en   = 1'b1;
            MEM_WB_en   = 1'b1;
            cnt_inc     = 1'b1;
          end else if (imem_stall) begin
            IF_ID_en    = 1'b1;
            IF_ID_flush = 1'b1;
            ID_EX_en    = 1'b1;
            EX_MEM_en   = 1'b1;
            MEM_WB_en   = 1'b1;
            cnt_inc     = 1'b1;
          end else if (halt_ID) begin
            IF_ID_en    = 1'b1;
            IF_ID_flush = 1'b1;
            ID_EX_en    = 1'b1;
            EX_MEM_en   = 1'b1;
            MEM_WB_en   = 1'b1;
            nxt_drain   = 2'd3;
            nxt_state   = DRAIN;
          end else begin
            pc_en     = 1'b1;
            IF_ID_en  = 1'b1;
            ID_EX_en  = 1'b1;
            EX_MEM_en = 1'b1;
            MEM_WB_en = 1'b1;
          end
        end
        DRAIN: begin
          if (dmem_stall) begin
            cnt_inc   = 1'b1;
            nxt_state = DMEM_WAIT;
            nxt_ret   = DRAIN;
          end else begin
            IF_ID_en    = 1'b1;
            IF_ID_flush = 1'b1;
            ID_EX_en    = 1'b1;
            EX_MEM_en   = 1'b1;
            MEM_WB_en   = 1'b1;
            if (drain_cnt <= 2'd1) begin
              nxt_drain = 2'd0;
              nxt_state = HALTED;
            end else begin
              nxt_drain = drain_cnt - 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      ret_state <= RUN;
      drain_cnt <= 2'd0;
      halted    <= 1'b0;
      stall_cnt <= 16'd0;
    end else begin
      state     <= nxt_state;
      ret_state <= nxt_ret;
      drain_cnt <= nxt_drain;
      halted    <= (nxt_state == HALTED);
      if (cnt_inc && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a queue of expected enable/flush patterns.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall_hazard, branch_taken_EX;
  logic        halt_ID, imem_stall, dmem_stall;
  logic        pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en;
  logic        IF_ID_flush, ID_EX_flush, halted;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } exp_t;

  exp_t sb[$];

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
  localparam logic [6:0] P_ALL = 7'b11111_00;
  localparam logic [6:0] P_RST = 7'b00000_11;
  localparam logic [6:0] P_NON = 7'b00000_00;
  localparam logic [6:0] P_BR  = 7'b11111_11;
  localparam logic [6:0] P_HAZ = 7'b00111_01;
  localparam logic [6:0] P_IFF = 7'b01111_10;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .stall_hazard    (stall_hazard),
    .branch_taken_EX (branch_taken_EX),
    .halt_ID         (halt_ID),
    .imem_stall      (imem_stall),
    .dmem_stall      (dmem_stall),
    .pc_en           (pc_en),
    .IF_ID_en        (IF_ID_en),
    .ID_EX_en        (ID_EX_en),
    .EX_MEM_en       (EX_MEM_en),
    .MEM_WB_en       (MEM_WB_en),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EX_flush     (ID_EX_flush),
    .halted          (halted),
    .stall_cnt       (stall_cnt)
  );

  wire [6:0] obs = {pc_en, IF_ID_en, ID_EX_en,
                    EX_MEM_en, MEM_WB_en,
                    IF_ID_flush, ID_EX_flush};

  // Drive one cycle, check the comb pattern, advance past the edge.
  task automatic cyc(input string tag, input logic r,
                     input logic ds, input logic br,
                     input logic hz, input logic im,
                     input logic hl, input logic [6:0] e);
    exp_t x;
    rst = r; dmem_stall = ds; branch_taken_EX = br;
    stall_hazard = hz; imem_stall = im; halt_ID = hl;
    sb.push_back('{tag, e});
    #3;
    x = sb.pop_front();
    checks++;
    assert (obs === x.exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", x.tag, obs, x.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] o,
                     input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  initial begin
    #1;
    cyc("rst0", 1, 0, 0, 0, 0, 0, P_RST);
    cyc("rst1", 1, 0, 0, 0, 0, 0, P_RST);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_cnt", stall_cnt, 16'd0);

    for (int i = 0; i < 5; i++)
      cyc("idle", 0, 0, 0, 0, 0, 0, P_ALL);
    chk("idle_cnt", stall_cnt, 16'd0);
    chk("idle_halted", {15'd0, halted}, 16'd0);

    cyc("haz0", 0, 0, 0, 1, 0, 0, P_HAZ);
    cyc("haz1", 0, 0, 0, 1, 0, 0, P_HAZ);
    chk("haz_cnt", stall_cnt, 16'd2);

    cyc("br_squash", 0, 0, 1, 1, 0, 1, P_BR);
    chk("br_cnt", stall_cnt, 16'd2);
    cyc("br_stay_run", 0, 0, 0, 0, 0, 0, P_ALL);

    cyc("imem", 0, 0, 0, 0, 1, 0, P_IFF);
    chk("imem_cnt", stall_cnt, 16'd3);

    cyc("dm_run0", 0, 1, 0, 0, 0, 0, P_NON);
    cyc("dm_run1", 0, 1, 1, 1, 1, 1, P_NON);
    cyc("dm_rel_haz", 0, 0, 0, 1, 0, 0, P_HAZ);
    chk("dm_run_cnt", stall_cnt, 16'd6);
    cyc("dm_after", 0, 0, 0, 0, 0, 0, P_ALL);

    cyc("halt_acc", 0, 0, 0, 0, 0, 1, P_IFF);
    cyc("drain3", 0, 0, 0, 0, 0, 0, P_IFF);
    cyc("dm_drain0", 0, 1, 0, 0, 0, 0, P_NON);
    cyc("dm_drain1", 0, 1, 0, 0, 0, 0, P_NON);
    cyc("dm_drain2", 0, 1, 0, 0, 0, 0, P_NON);
    chk("dm_drain_cnt", stall_cnt, 16'd9);
    cyc("drain_rel", 0, 0, 0, 0, 0, 0, P_IFF);
    chk("drain_rel_halted", {15'd0, halted}, 16'd0);
    cyc("drain_last", 0, 0, 0, 0, 0, 0, P_IFF);
    chk("drain_halted", {15'd0, halted}, 16'd1);

    cyc("hlt_haz", 0, 0, 0, 1, 0, 0, P_NON);
    cyc("hlt_imem", 0, 0, 0, 0, 1, 0, P_NON);
    cyc("hlt_br", 0, 0, 1, 0, 0, 0, P_NON);
    cyc("hlt_dm", 0, 1, 0, 0, 0, 0, P_NON);
    chk("hlt_cnt", stall_cnt, 16'd9);
    chk("hlt_stays", {15'd0, halted}, 16'd1);

    cyc("rst_hlt", 1, 0, 0, 0, 0, 0, P_RST);
    chk("rst_hlt_halted", {15'd0, halted}, 16'd0);
    chk("rst_hlt_cnt", stall_cnt, 16'd0);
    cyc("post_rst", 0, 0, 0, 0, 0, 0, P_ALL);

    cyc("h4_e1", 0, 0, 0, 0, 0, 1, P_IFF);
    chk("h4_1", {15'd0, halted}, 16'd0);
    cyc("h4_e2", 0, 0, 0, 0, 0, 0, P_IFF);
    chk("h4_2", {15'd0, halted}, 16'd0);
    cyc("h4_e3", 0, 0, 0, 0, 0, 0, P_IFF);
    chk("h4_3", {15'd0, halted}, 16'd0);
    cyc("h4_e4", 0, 0, 0, 0, 0, 0, P_IFF);
    chk("h4_4", {15'd0, halted}, 16'd1);
    cyc("h4_haz", 0, 0, 0, 1, 1, 0, P_NON);
    chk("h4_cnt", stall_cnt, 16'd0);

    cyc("rst_a", 1, 0, 0, 0, 0, 0, P_RST);
    cyc("mid_halt", 0, 0, 0, 0, 0, 1, P_IFF);
    cyc("mid_dm", 0, 1, 0, 0, 0, 0, P_NON);
    cyc("mid_rst", 1, 1, 0, 0, 0, 0, P_RST);
    chk("mid_cnt", stall_cnt, 16'd0);
    cyc("mid_run", 0, 0, 0, 0, 0, 0, P_ALL);
    cyc("mid_run2", 0, 0, 0, 0, 0, 0, P_ALL);
    chk("mid_halted", {15'd0, halted}, 16'd0);

    cyc("sat_rst", 1, 0, 0, 0, 0, 0, P_RST);
    rst = 0; imem_stall = 1;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat", stall_cnt, 16'hFFFF);
    cyc("sat_hold", 0, 0, 0, 0, 1, 0, P_IFF);
    chk("sat_hold_cnt", stall_cnt, 16'hFFFF);
    cyc("sat_rst2", 1, 0, 0, 0, 1, 0, P_RST);
    chk("sat_clear", stall_cnt, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, named as follows.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 stall_hazard  input  1  load-use/RAW stall request from the hazard detection logic for the instruction in ID.
REQ-005 branch_taken_EX  input  1  branch/jump in EX resolved taken; PC loads target this cycle.
REQ-006 halt_ID  input  1  HALT instruction present in ID.
REQ-007 imem_stall  input  1  instruction memory not ready this cycle.
REQ-008 dmem_stall  input  1  data memory not ready this cycle.
REQ-009 pc_en  output  1  PC register write enable.
REQ-010 IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en  output  1 each  pipeline register write enables.
REQ-011 IF_ID_flush, ID_EX_flush  output  1 each  load NOP into that pipeline register on the next edge (only effective while the matching en=1).
REQ-012 halted  output  1  registered; processor halted, pipeline drained.
REQ-013 stall_cnt  output  16  registered; saturating count of stall cycles.

Function
REQ-014 The FSM SHALL have states RUN, DMEM_WAIT, DRAIN, HALTED; enables/flushes are combinational from state and inputs.
REQ-015 RUN, priority high to low: dmem_stall, branch_taken_EX, stall_hazard, imem_stall, halt_ID, otherwise all en=1, flushes=0.
REQ-016 dmem_stall in RUN or DRAIN: all en=0, flushes=0; state -> DMEM_WAIT (remembering return state).
REQ-017 DMEM_WAIT: all en=0 while dmem_stall=1; the first cycle dmem_stall=0, return to the remembered state and apply that state's rules in the same cycle.
REQ-018 branch_taken_EX: pc_en=1, all en=1, IF_ID_flush=1, ID_EX_flush=1; concurrent stall_hazard, imem_stall and halt_ID are ignored (squashed).
REQ-019 stall_hazard (no branch): pc_en=0, IF_ID_en=0, ID_EX_en=1 with ID_EX_flush=1, EX_MEM_en=MEM_WB_en=1.
REQ-020 imem_stall alone: pc_en=0, IF_ID_en=1 with IF_ID_flush=1, remaining en=1.
REQ-021 halt_ID accepted (no higher-priority event): pc_en=0, IF_ID_en=1, IF_ID_flush=1, other en=1; load drain_cnt=3; state -> DRAIN.
REQ-022 DRAIN: pc_en=0, IF_ID_flush=1, other en=1; drain_cnt decrements each cycle without dmem_stall; at drain_cnt reaching 0 -> HALTED.
REQ-023 HALTED: all en=0, flushes=0, halted=1; all inputs ignored; exits only on rst.
REQ-024 stall_cnt SHALL increment on every cycle in RUN/DMEM_WAIT/DRAIN in which pc_en=0 because of dmem_stall, stall_hazard or imem_stall, saturating at 16'hFFFF (no wrap).
REQ-025 Halt-induced pc_en=0 cycles and HALTED cycles SHALL NOT count.

Reset
REQ-026 While rst=1: all en=0, IF_ID_flush=ID_EX_flush=1; on that edge state=RUN, halted=0, stall_cnt=0, drain_cnt=0, return state=RUN.
REQ-027 rst asserted in any state, including mid-DRAIN or DMEM_WAIT, SHALL take effect on the next edge with no residual state.

Verification
REQ-028 Reset, then no requests for 5 cycles -> all en=1, flushes=0, stall_cnt=0, halted=0.
REQ-029 stall_hazard=1 for 2 cycles -> pc_en=0, IF_ID_en=0, ID_EX_flush=1 both cycles; stall_cnt=2.
REQ-030 branch_taken_EX=1 with stall_hazard=1 and halt_ID=1 same cycle -> pc_en=1, both flushes=1, state stays RUN, stall_cnt unchanged.
REQ-031 dmem_stall=1 for 3 cycles during DRAIN (drain_cnt=2) -> all en=0 for 3 cycles, drain_cnt held at 2; HALTED reached 2 cycles after release.
REQ-032 halt_ID=1 in RUN, no stalls -> halted=1 after exactly 4 edges; afterwards stall_hazard/imem_stall have no effect.
REQ-033 Preload via 65540 imem_stall cycles -> stall_cnt=16'hFFFF and holds; rst -> stall_cnt=0.
